imm_extend_pipe: RTL

- Registered, parametrised successor to the decode-stage immediate extender.
- Produces XLEN-wide immediates from the 26-bit instruction immediate field, with a valid/ready handshake on both sides and a sideband tag passthrough.
- Adds an upper/lower fusion mode: an upper type-D op marked for fusion is held, and the following lower type-D op emits one summed constant.
- Sits between the instruction decoder and the register-read/issue stage.

---
 rtl/imm_extend_pipe.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready handshake and upper/lower-D fusion.
// Define IMM_EXT_FUSE_STATS_EN to add the saturating fused-beat counter port fuse_cnt_o.
module imm_extend_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [25:0]      imm_in_i,
   input  logic [3:0]       imm_src_i,
   input  logic             fuse_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  imm_o,
   output logic [TAG_W-1:0] tag_o,
   output logic             fused_o
`ifdef IMM_EXT_FUSE_STATS_EN
   ,
   output logic [15:0]      fuse_cnt_o
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PEND  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [XLEN-1:0]  pend_q, hold_imm_q;
   logic [TAG_W-1:0] pend_tag_q, hold_tag_q;
   logic [XLEN-1:0]  ext_val;
   logic             is_upper, is_lower_d, accept, slot_free;
   logic             beat_valid, beat_fused, load_pend, load_hold;
   logic [XLEN-1:0]  beat_imm;
   logic [TAG_W-1:0] beat_tag;

   // Upper ignores the sign-select bit: it always extends from imm[25].
   function automatic logic [XLEN-1:0] extend(input logic [25:0] imm, input logic [3:0] src);
      logic            sign;
      logic [XLEN-1:0] r;
      sign = src[0] ? 1'b0 : imm[25];
      r    = {XLEN{sign}};
      if (src[1]) begin
         r        = {XLEN{imm[25]}};
         r[31:0]  = {imm[25:5], 11'b0};
      end else begin
         case (src[3:2])
            2'b00:   r[15:0] = imm[25:10];
            2'b01:   r[15:0] = {imm[25:15], imm[4:0]};
            2'b10:   r[17:0] = {imm[25:15], imm[4:0], 2'b00};
            default: r[20:0] = imm[25:5];
         endcase
      end
      return r;
   endfunction

   assign ext_val    = extend(imm_in_i, imm_src_i);
   assign is_upper   = imm_src_i[1];
   assign is_lower_d = !imm_src_i[1] && (imm_src_i[3:2] == 2'b11);
   assign slot_free  = !out_valid_o || out_ready_i;
   assign in_ready_o = slot_free && (state != ST_FLUSH) && !flush_i;
   assign accept     = in_valid_i && in_ready_o;

   always_comb begin
      state_nxt  = state;
      beat_valid = 1'b0;
      beat_imm   = ext_val;
      beat_tag   = tag_i;
      beat_fused = 1'b0;
      load_pend  = 1'b0;
      load_hold  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (is_upper && fuse_i) begin
                  load_pend = 1'b1;
                  state_nxt = ST_PEND;
               end else begin
                  beat_valid = 1'b1;
               end
            end
         end
         ST_PEND: begin
            if (accept) begin
               beat_valid = 1'b1;
               beat_imm   = pend_q;
               beat_tag   = pend_tag_q;
               if (is_lower_d) begin
                  beat_imm   = pend_q + ext_val;
                  beat_tag   = tag_i;
                  beat_fused = 1'b1;
                  state_nxt  = ST_IDLE;
               end else if (is_upper && fuse_i) begin
                  load_pend = 1'b1;
               end else begin
                  // Broken pair: the stale upper goes out now, the new op waits one cycle.
                  load_hold = 1'b1;
                  state_nxt = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            if (slot_free) begin
               beat_valid = 1'b1;
               beat_imm   = hold_imm_q;
               beat_tag   = hold_tag_q;
               state_nxt  = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else if (flush_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q     <= '0;
         pend_tag_q <= '0;
         hold_imm_q <= '0;
         hold_tag_q <= '0;
      end else if (flush_i) begin
         pend_q     <= '0;
         pend_tag_q <= '0;
         hold_imm_q <= '0;
         hold_tag_q <= '0;
      end else begin
         if (load_pend) begin
            pend_q     <= ext_val;
            pend_tag_q <= tag_i;
         end
         if (load_hold) begin
            hold_imm_q <= ext_val;
            hold_tag_q <= tag_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_o <= 1'b0;
         imm_o       <= '0;
         tag_o       <= '0;
         fused_o     <= 1'b0;
      end else if (flush_i) begin
         out_valid_o <= 1'b0;
      end else if (beat_valid) begin
         out_valid_o <= 1'b1;
         imm_o       <= beat_imm;
         tag_o       <= beat_tag;
         fused_o     <= beat_fused;
      end else if (out_ready_i) begin
         out_valid_o <= 1'b0;
      end
   end

`ifdef IMM_EXT_FUSE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fuse_cnt_o <= '0;
      end else if (out_valid_o && out_ready_i && fused_o && (fuse_cnt_o != 16'hFFFF)) begin
         fuse_cnt_o <= fuse_cnt_o + 16'd1;
      end
   end
`endif

endmodule
